// File: rtl/sort_rr_scheduler.sv
// sort_rr_scheduler
// Round-robin front end for a fixed-latency pipelined sorter. Two requesters
// offer sort jobs, and at most one job is accepted per cycle. The accepted
// vector is registered into the sorter. A {valid, id} tag travels alongside
// the sorter pipeline so that each result comes back out with its owner's id.
//
// Parameters
//   DATA_WIDTH   element width in bits
//   NUM_ELEMS    elements per job (vector width W = NUM_ELEMS*DATA_WIDTH)
//   SORT_LATENCY pipeline depth of the attached sorter, 1..15
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0_valid/data/ready       requester 0 job handshake
//   req1_valid/data/ready       requester 1 job handshake
//   sorter_inps (out, W)        registered vector into the sorter
//   sorter_outp (in, W)         sorter result
//   rsp_valid/id/data (out)     one-cycle response with owner id and sorted data
//   inflight (out, 5)           accepted jobs not yet responded
//
// Optional feature (macro SORT_RR_SCHEDULER_STATS_EN):
//   grant0_cnt, grant1_cnt (out, 8) saturating per-requester acceptance counts
module sort_rr_scheduler #(
  parameter int DATA_WIDTH   = 3,
  parameter int NUM_ELEMS    = 4,
  parameter int SORT_LATENCY = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req0_valid,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0]  req0_data,
  output logic                             req0_ready,
  input  logic                             req1_valid,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0]  req1_data,
  output logic                             req1_ready,
  output logic [NUM_ELEMS*DATA_WIDTH-1:0]  sorter_inps,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0]  sorter_outp,
  output logic                             rsp_valid,
  output logic                             rsp_id,
  output logic [NUM_ELEMS*DATA_WIDTH-1:0]  rsp_data,
  output logic [4:0]                       inflight
`ifdef SORT_RR_SCHEDULER_STATS_EN
  ,
  output logic [7:0]                       grant0_cnt,
  output logic [7:0]                       grant1_cnt
`endif
);

  localparam int W = NUM_ELEMS * DATA_WIDTH;

  // Requester that wins the next conflict; 0 after reset.
  logic                  r_prio;
  logic [W-1:0]          r_sorter_inps;
  logic [SORT_LATENCY:0] r_tag_vld;
  logic [SORT_LATENCY:0] r_tag_id;
  logic                  r_rsp_valid;
  logic                  r_rsp_id;
  logic [W-1:0]          r_rsp_data;
  logic [4:0]            r_inflight;

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_accept;
  logic                  w_acc_id;
  logic [W-1:0]          w_acc_data;
  logic                  w_rsp_fire;

  // Grants are gated by rst_n so that neither ready can rise while reset is held.
  always_comb begin
    w_gnt0     = rst_n & req0_valid & (~req1_valid | ~r_prio);
    w_gnt1     = rst_n & req1_valid & (~req0_valid | r_prio);
    w_accept   = w_gnt0 | w_gnt1;
    w_acc_id   = w_gnt1;
    w_acc_data = w_gnt1 ? req1_data : req0_data;
  end

  // The tag in the last stage matches the result now present on sorter_outp.
  assign w_rsp_fire = r_tag_vld[SORT_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio        <= 1'b0;
      r_sorter_inps <= '0;
      r_tag_vld     <= '0;
      r_tag_id      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_data    <= '0;
      r_inflight    <= 5'd0;
    end else begin
      if (w_accept) begin
        r_prio <= ~w_acc_id;
      end
      r_sorter_inps <= w_accept ? w_acc_data : '0;
      r_tag_vld     <= {r_tag_vld[SORT_LATENCY-1:0], w_accept};
      r_tag_id      <= {r_tag_id[SORT_LATENCY-1:0], w_acc_id};

      r_rsp_valid <= w_rsp_fire;
      if (w_rsp_fire) begin
        r_rsp_id   <= r_tag_id[SORT_LATENCY];
        r_rsp_data <= sorter_outp;
      end

      // A job counts as retired at the edge that issues its response.
      unique case ({w_accept, w_rsp_fire})
        2'b10:   r_inflight <= r_inflight + 5'd1;
        2'b01:   r_inflight <= r_inflight - 5'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;
  assign sorter_inps = r_sorter_inps;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = r_rsp_data;
  assign inflight    = r_inflight;

`ifdef SORT_RR_SCHEDULER_STATS_EN
  logic [7:0] r_grant0_cnt;
  logic [7:0] r_grant1_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant0_cnt <= 8'd0;
      r_grant1_cnt <= 8'd0;
    end else begin
      if (w_gnt0 && (r_grant0_cnt != 8'hFF)) begin
        r_grant0_cnt <= r_grant0_cnt + 8'd1;
      end
      if (w_gnt1 && (r_grant1_cnt != 8'hFF)) begin
        r_grant1_cnt <= r_grant1_cnt + 8'd1;
      end
    end
  end

  assign grant0_cnt = r_grant0_cnt;
  assign grant1_cnt = r_grant1_cnt;
`endif

endmodule

// File: doc/sort_rr_scheduler.md
SORT_RR_SCHEDULER -- requirements
Module: sort_rr_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 3, element width in bits.
REQ-002 SHALL have parameter NUM_ELEMS, default 4, elements per sort job; vector width W = NUM_ELEMS*DATA_WIDTH.
REQ-003 SHALL have parameter SORT_LATENCY, default 3, fixed pipeline depth of the attached sorter in cycles; legal range 1..15.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock (the only clock); rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: req0_valid  in  1  job offered by requester 0; req0_data  in  W  unsorted vector; req0_ready  out  1  job accepted this cycle.
REQ-006 SHALL have ports: req1_valid  in  1; req1_data  in  W; req1_ready  out  1; same meaning for requester 1.
REQ-007 SHALL have ports: sorter_inps  out  W  registered vector driven into the pipelined sorter; sorter_outp  in  W  sorter result.
REQ-008 SHALL have ports: rsp_valid  out  1  result valid; rsp_id  out  1  requester owning the result; rsp_data  out  W  sorted vector.
REQ-009 SHALL have port: inflight  out  5  number of accepted jobs whose response has not yet been issued.

Function
REQ-010 SHALL accept at most one job per cycle; a job is accepted at a rising edge where reqN_valid and reqN_ready are both 1.
REQ-011 SHALL drive req0_ready/req1_ready combinationally from the current valids and the round-robin pointer; never both 1 in the same cycle.
REQ-012 SHALL grant the sole valid requester when only one is valid, regardless of the pointer.
REQ-013 SHALL, when both are valid, grant the requester other than the last one granted; after reset requester 0 wins the first conflict.
REQ-014 SHALL update the round-robin pointer only on an accepted job; idle cycles leave it unchanged.
REQ-015 SHALL load sorter_inps with the accepted data at the acceptance edge E, and load all-zeros at edges with no acceptance.
REQ-016 SHALL carry a {valid, id} tag through a SORT_LATENCY+1 stage shift register aligned with the sorter pipeline.
REQ-017 SHALL register rsp_valid=1, rsp_id, and rsp_data=sorter_outp at edge E+SORT_LATENCY+1; rsp_valid is high for exactly one cycle per job.
REQ-018 SHALL drive rsp_valid=0 in all other cycles; rsp_data and rsp_id hold their last value while rsp_valid=0.
REQ-019 SHALL accept a new job every cycle (throughput 1/cycle); responses are never back-pressured and emerge in acceptance order.
REQ-020 SHALL increment inflight on acceptance, decrement on rsp_valid, and leave it unchanged when both occur in the same cycle; it never exceeds SORT_LATENCY+1.

Reset
REQ-021 SHALL, on rst_n low, asynchronously clear sorter_inps, rsp_valid, rsp_id, rsp_data, inflight, all tag stages, and the pointer (requester 0 preferred).
REQ-022 SHALL drop all in-flight jobs when reset is asserted mid-operation; no rsp_valid is produced for them after release.
REQ-023 SHALL hold req0_ready and req1_ready at 0 while rst_n is low.

Configuration
REQ-024 SHALL, with macro SORT_RR_SCHEDULER_STATS_EN defined, add outputs grant0_cnt and grant1_cnt (8 bits each), counting acceptances per requester, saturating at 255, cleared by reset.
REQ-025 SHALL, without SORT_RR_SCHEDULER_STATS_EN, omit those ports and counters entirely; all other behaviour is identical.

Verification
REQ-026 SHALL cover: req0_valid=1 only, data 12'o3120 at edge 5 -> sorter_inps=12'o3120 after edge 5; rsp_valid=1, rsp_id=0 after edge 9 (SORT_LATENCY=3); inflight 1 then 0.
REQ-027 SHALL cover: both valid continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; responses return in that id order on 6 consecutive cycles.
REQ-028 SHALL cover: req1 valid alone for 2 cycles, then both valid -> the next grant goes to requester 0.
REQ-029 SHALL cover: 4 back-to-back accepts then idle -> inflight reaches 4 (=SORT_LATENCY+1) then counts down to 0; rsp_data equals the bench sorter model output for each job.
REQ-030 SHALL cover: rst_n pulsed low with 3 jobs in flight -> all outputs 0 immediately; no rsp_valid for 10 cycles after release with valids low.
REQ-031 SHALL cover: STATS_EN build, 300 req0 accepts -> grant0_cnt=255, grant1_cnt=0.
